// File: rtl/vga_mem_dispatch_if.sv
// CPU-side access port of the video memory dispatcher: a held request
// answered by a one-clock acknowledge that carries read data.
interface vga_mem_dispatch_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/vga_mem_dispatch.sv
// Time-multiplexes one single-port video memory between the per-pixel text/glyph
// fetch (phases 0/1) and CPU accesses (phases 2/3) in front of VGA_Controller.
module vga_mem_dispatch #(
  parameter logic [15:0] GLYPH_BASE = 16'h0000,
  parameter int          ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        SubPixelCount,
  input  logic [1:0]        LineCount,
  input  logic [15:0]       TextAreaAddress,
  output logic [15:0]       ASCIIColChar,
  output logic [15:0]       GlyphWord,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  vga_mem_dispatch_if.slave cpu,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    PH_TEXT  = 2'd0,
    PH_GLYPH = 2'd1,
    PH_CPU_A = 2'd2,
    PH_CPU_B = 2'd3
  } phase_t;

  phase_t              phase;
  logic                grant;
  logic                ack_pending;
  logic                ack_rd;
  logic [15:0]         rdata_hold;
  logic [15:0]         char_p1;
  logic [1:0]          prev_spc;
  logic                chk_en;
  logic [ADDR_W-1:0]   glyph_addr;

  assign phase = phase_t'(SubPixelCount);

  // Glyph entry is 4 words per character; the text word arrives on mem_rdata in phase 1.
  assign glyph_addr = ADDR_W'(GLYPH_BASE)
                    + ADDR_W'({6'b0, mem_rdata[7:0], 2'b00})
                    + ADDR_W'(LineCount);

  always_comb begin
    grant     = 1'b0;
    mem_addr  = ADDR_W'(cpu.cpu_addr);
    mem_we    = 1'b0;
    mem_wdata = cpu.cpu_wdata;
    case (phase)
      PH_TEXT:  mem_addr = ADDR_W'(TextAreaAddress);
      PH_GLYPH: mem_addr = glyph_addr;
      default: begin
        // The ack cycle blocks a new grant so a held request is served once.
        grant  = cpu.cpu_req & ~ack_pending;
        mem_we = grant & cpu.cpu_we & rst;
      end
    endcase
  end

  assign cpu.cpu_ack   = ack_pending;
  assign cpu.cpu_rdata = ack_rd ? mem_rdata : rdata_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_pending  <= 1'b0;
      ack_rd       <= 1'b0;
      rdata_hold   <= '0;
      char_p1      <= '0;
      ASCIIColChar <= '0;
      GlyphWord    <= '0;
      prev_spc     <= '0;
      chk_en       <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      // CPU stage: grant edge -> ack cycle, read data captured at end of ack
      ack_pending <= grant;
      ack_rd      <= grant & ~cpu.cpu_we;
      if (ack_rd)
        rdata_hold <= mem_rdata;

      // Display stage p1: text word latched at the end of phase 1
      if (phase == PH_GLYPH)
        char_p1 <= mem_rdata;

      // Display stage p2: text and glyph presented together at the end of phase 2
      if (phase == PH_CPU_A) begin
        ASCIIColChar <= char_p1;
        GlyphWord    <= mem_rdata;
      end

      prev_spc <= SubPixelCount;
      chk_en   <= 1'b1;
      if (chk_en && (SubPixelCount != prev_spc + 2'd1))
        seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_mem_dispatch.sv
// Directed bench for vga_mem_dispatch: display fetch, CPU slots, sequence error,
// reset abort and glyph address wrap on a second instance with a high glyph base.
module tb_vga_mem_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  spc = 2'd0;
  logic [1:0]  LineCount = 2'd0;
  logic [15:0] TextAreaAddress = 16'h0000;
  logic [15:0] ASCIIColChar, GlyphWord;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        seq_err;

  logic [15:0] wrap_ascii, wrap_glyph, wrap_addr, wrap_wdata;
  logic        wrap_we, wrap_seq_err;
  logic [15:0] wrap_rdata = 16'h0000;

  logic [15:0] mem [0:65535];
  logic        preload_en = 1'b0;
  logic [15:0] preload_addr = 16'h0000;
  logic [15:0] preload_data = 16'h0000;

  int checks = 0;
  int errors = 0;

  vga_mem_dispatch_if cpu_bus ();
  vga_mem_dispatch_if wrap_bus ();

  vga_mem_dispatch #(.GLYPH_BASE(16'h0000), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .SubPixelCount(spc), .LineCount(LineCount),
    .TextAreaAddress(TextAreaAddress), .ASCIIColChar(ASCIIColChar), .GlyphWord(GlyphWord),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu(cpu_bus.slave), .seq_err(seq_err)
  );

  vga_mem_dispatch #(.GLYPH_BASE(16'hFFFC), .ADDR_W(16)) u_wrap (
    .clk(clk), .rst(rst), .SubPixelCount(spc), .LineCount(LineCount),
    .TextAreaAddress(TextAreaAddress), .ASCIIColChar(wrap_ascii), .GlyphWord(wrap_glyph),
    .mem_addr(wrap_addr), .mem_we(wrap_we), .mem_wdata(wrap_wdata), .mem_rdata(wrap_rdata),
    .cpu(wrap_bus.slave), .seq_err(wrap_seq_err)
  );

  always #5 clk = ~clk;

  // Single-port memory, registered read with one clock latency
  always @(posedge clk) begin
    if (preload_en)
      mem[preload_addr] <= preload_data;
    else if (mem_we)
      mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [15:0] rdata;
    logic [1:0]  line;
    logic [15:0] exp_addr;
  } wrap_vec_t;

  wrap_vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    spc = spc + 2'd1;
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    int n;
    n = 0;
    while (spc != p && n < 8) begin
      step();
      n++;
    end
    chk("wait_phase", 32'(spc), 32'(p));
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    preload_addr = a;
    preload_data = d;
    preload_en   = 1'b1;
    step();
    preload_en   = 1'b0;
  endtask

  initial begin
    int acks, consec, badg;
    logic prev_ack;

    vecs[0] = '{16'h0000, 2'd3, 16'hFFFF};
    vecs[1] = '{16'h00FF, 2'd0, 16'h03F8};
    vecs[2] = '{16'hE041, 2'd1, 16'h0101};
    vecs[3] = '{16'hFF80, 2'd2, 16'h01FE};
    vecs[4] = '{16'h00FF, 2'd3, 16'h03FB};

    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = 1'b1;
    cpu_bus.cpu_addr  = 16'h0310;
    cpu_bus.cpu_wdata = 16'h5555;
    wrap_bus.cpu_req   = 1'b0;
    wrap_bus.cpu_we    = 1'b0;
    wrap_bus.cpu_addr  = 16'h0000;
    wrap_bus.cpu_wdata = 16'h0000;

    preload(16'h0200, 16'hE041);
    preload(16'h0104, 16'h1818);
    preload(16'h0105, 16'h243C);
    preload(16'h0106, 16'h4242);
    preload(16'h0107, 16'h0000);
    preload(16'h0201, 16'h0C42);
    preload(16'h0109, 16'h5A5A);
    preload(16'h0300, 16'h0000);
    preload(16'h0310, 16'h0000);

    // Held in reset with a write request in a CPU phase
    wait_phase(2'd2);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ascii", 32'(ASCIIColChar), 32'h0);
    chk("rst_glyph", 32'(GlyphWord), 32'h0);
    chk("rst_ack", 32'(cpu_bus.cpu_ack), 32'd0);
    chk("rst_rdata", 32'(cpu_bus.cpu_rdata), 32'h0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    cpu_bus.cpu_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();

    // Display fetch: text 0x0200 then glyph 'A' row 1
    wait_phase(2'd0);
    TextAreaAddress = 16'h0200;
    LineCount = 2'd1;
    #1;
    chk("ph0_addr", 32'(mem_addr), 32'h0200);
    chk("ph0_we", 32'(mem_we), 32'd0);
    step();
    chk("ph1_addr", 32'(mem_addr), 32'h0105);
    chk("ph1_we", 32'(mem_we), 32'd0);
    step();
    step();
    TextAreaAddress = 16'h0201;
    for (int k = 0; k < 4; k++) begin
      chk("disp_ascii_stable", 32'(ASCIIColChar), 32'hE041);
      chk("disp_glyph_stable", 32'(GlyphWord), 32'h243C);
      step();
    end
    chk("disp_ascii_next", 32'(ASCIIColChar), 32'h0C42);
    chk("disp_glyph_next", 32'(GlyphWord), 32'h5A5A);

    // CPU write requested in phase 0
    step();
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = 1'b1;
    cpu_bus.cpu_addr  = 16'h0300;
    cpu_bus.cpu_wdata = 16'hABCD;
    #1;
    chk("wr_ph0_we", 32'(mem_we), 32'd0);
    chk("wr_ph0_addr", 32'(mem_addr), 32'h0201);
    step();
    chk("wr_ph1_we", 32'(mem_we), 32'd0);
    step();
    chk("wr_ph2_we", 32'(mem_we), 32'd1);
    chk("wr_ph2_addr", 32'(mem_addr), 32'h0300);
    chk("wr_ph2_wdata", 32'(mem_wdata), 32'hABCD);
    chk("wr_ph2_ack", 32'(cpu_bus.cpu_ack), 32'd0);
    step();
    chk("wr_ph3_ack", 32'(cpu_bus.cpu_ack), 32'd1);
    chk("wr_ph3_we", 32'(mem_we), 32'd0);
    cpu_bus.cpu_req = 1'b0;
    step();
    chk("wr_ack_pulse", 32'(cpu_bus.cpu_ack), 32'd0);
    chk("wr_ascii_kept", 32'(ASCIIColChar), 32'h0C42);
    chk("wr_glyph_kept", 32'(GlyphWord), 32'h5A5A);
    chk("wr_mem", 32'(mem[16'h0300]), 32'hABCD);

    // CPU read requested in phase 3, acked in phase 0
    wait_phase(2'd3);
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_we   = 1'b0;
    cpu_bus.cpu_addr = 16'h0300;
    #1;
    chk("rd_ph3_addr", 32'(mem_addr), 32'h0300);
    chk("rd_ph3_we", 32'(mem_we), 32'd0);
    chk("rd_ph3_ack", 32'(cpu_bus.cpu_ack), 32'd0);
    step();
    chk("rd_ph0_ack", 32'(cpu_bus.cpu_ack), 32'd1);
    chk("rd_ph0_rdata", 32'(cpu_bus.cpu_rdata), 32'hABCD);
    chk("rd_ph0_addr", 32'(mem_addr), 32'h0201);
    cpu_bus.cpu_req = 1'b0;
    step();
    chk("rd_ph1_ack", 32'(cpu_bus.cpu_ack), 32'd0);
    chk("rd_rdata_held", 32'(cpu_bus.cpu_rdata), 32'hABCD);
    chk("rd_ph1_addr", 32'(mem_addr), 32'h0109);
    wait_phase(2'd3);
    chk("rd_ascii_kept", 32'(ASCIIColChar), 32'h0C42);
    chk("rd_glyph_kept", 32'(GlyphWord), 32'h5A5A);

    // Request held for 12 clocks
    wait_phase(2'd0);
    cpu_bus.cpu_req  = 1'b1;
    cpu_bus.cpu_we   = 1'b0;
    cpu_bus.cpu_addr = 16'h0300;
    acks = 0;
    consec = 0;
    badg = 0;
    prev_ack = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (cpu_bus.cpu_ack) acks++;
      if (cpu_bus.cpu_ack && prev_ack) consec++;
      prev_ack = cpu_bus.cpu_ack;
      if ((spc == 2'd0 || spc == 2'd1) && mem_addr == cpu_bus.cpu_addr) badg++;
      step();
    end
    cpu_bus.cpu_req = 1'b0;
    chk("held_ack_count", 32'(acks), 32'd3);
    chk("held_consec_ack", 32'(consec), 32'd0);
    chk("held_grant_ph01", 32'(badg), 32'd0);
    chk("held_rdata", 32'(cpu_bus.cpu_rdata), 32'hABCD);

    // Phase sequence 0,1,2,0
    chk("seq_err_clear", 32'(seq_err), 32'd0);
    wait_phase(2'd2);
    step();
    spc = 2'd0;
    #1;
    step();
    chk("seq_err_set", 32'(seq_err), 32'd1);
    repeat (5) step();
    chk("seq_err_sticky", 32'(seq_err), 32'd1);

    // Reset pulse in phase 2 with a write being granted
    wait_phase(2'd2);
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = 1'b1;
    cpu_bus.cpu_addr  = 16'h0310;
    cpu_bus.cpu_wdata = 16'h1234;
    #1;
    chk("abort_grant_we", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_ascii", 32'(ASCIIColChar), 32'h0);
    chk("abort_glyph", 32'(GlyphWord), 32'h0);
    chk("abort_ack", 32'(cpu_bus.cpu_ack), 32'd0);
    chk("abort_rdata", 32'(cpu_bus.cpu_rdata), 32'h0);
    chk("abort_seq_err", 32'(seq_err), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    step();
    rst = 1'b1;
    cpu_bus.cpu_req = 1'b0;
    #1;
    chk("abort_no_ack_ph3", 32'(cpu_bus.cpu_ack), 32'd0);
    step();
    chk("abort_no_ack_ph0", 32'(cpu_bus.cpu_ack), 32'd0);
    chk("abort_no_write", 32'(mem[16'h0310]), 32'h0000);

    // Glyph address wrap with GLYPH_BASE=16'hFFFC
    foreach (vecs[v]) begin
      wait_phase(2'd1);
      LineCount  = vecs[v].line;
      wrap_rdata = vecs[v].rdata;
      #1;
      chk("wrap_glyph_addr", 32'(wrap_addr), 32'(vecs[v].exp_addr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 required");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_mem_dispatch.md
Name: vga_mem_dispatch

Overview:
- Sits directly upstream of VGA_Controller and time-multiplexes one single-port 16-bit video memory between the display fetch path and a CPU-side access port.
- Within each 4-clock pixel it performs two display reads:
  - the text word at TextAreaAddress (colour in [15:8], ASCII code in [7:0]);
  - the matching glyph word from the glyph table.
- It presents both to VGA_Controller as stable registered ASCIIColChar/GlyphWord.
- The remaining memory slots serve CPU reads and writes through a req/ack handshake.

Parameters:
- GLYPH_BASE, 16'h0000, word address of glyph table entry 0 (4 words per character).
- ADDR_W, 16, memory address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock (4 clocks per pixel)
- rst  in  1  asynchronous, active-low reset
- SubPixelCount  in  2  pixel phase from VGA_Controller, increments 0..3 every clock
- LineCount  in  2  glyph word row (LineCountOut[2:1] of VGA_Controller)
- TextAreaAddress  in  16  text word address for current pixel
- ASCIIColChar  out  16  registered text word to VGA_Controller
- GlyphWord  out  16  registered glyph word to VGA_Controller
- mem_addr  out  ADDR_W  memory address (combinational)
- mem_we  out  1  memory write enable (combinational)
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, registered, 1-clock latency
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_ack  out  1  one-clock completion pulse
- cpu_rdata  out  16  CPU read data, valid when cpu_ack=1, held until next read ack
- seq_err  out  1  sticky: SubPixelCount failed to advance by +1 mod 4

Behaviour:
- Reset (rst=0, async): ASCIIColChar=0, GlyphWord=0, cpu_ack=0, cpu_rdata=0, seq_err=0, internal char stage=0, ack_pending=0. mem_we=0 while rst=0.
- Phase 0 (display text read): mem_addr=TextAreaAddress, mem_we=0.
- Phase 1 (display glyph read):
  - char stage <= mem_rdata;
  - mem_addr = GLYPH_BASE + {6'b0, mem_rdata[7:0], 2'b00} + LineCount, computed combinationally from mem_rdata, 16-bit wrap;
  - mem_we=0.
- Phase 2 (CPU slot): edge ending phase 2 loads ASCIIColChar<=char stage and GlyphWord<=mem_rdata simultaneously.
  - Display outputs change only on this edge; they are first visible in phase 3 and stay stable for 4 clocks.
  - Fetch-to-output latency is 3 clocks from phase 0.
- Phase 3 (CPU slot): no display activity.
- CPU grant: grant = cpu_req & ~ack_pending & (SubPixelCount==2 or 3).
  - In a grant cycle: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - ack_pending<=1 on the grant edge.
- The clock after a grant: cpu_ack=1 and ack_pending clears. On a read, cpu_rdata<=mem_rdata in that clock, so it holds the read result from then on.
  - No grant is issued in the ack cycle, so a held cpu_req is never double-served.
  - The CPU must drop or replace the request after seeing ack.
  - Maximum throughput is one CPU access per pixel: grant phase 2, ack phase 3. A request first seen in phase 3 is granted there, acked in phase 0, and has its read data captured in phase 0 without disturbing the display fetch.
- cpu_req outside phases 2/3 waits. There is no timeout; the wait is at most 3 clocks.
- Non-grant cycles in phases 2/3: mem_addr=cpu_addr, mem_we=0, mem_wdata=cpu_wdata (don't-care for memory).
- seq_err: a previous-phase register (reset 0, first check one clock after reset release) sets seq_err when SubPixelCount != prev+1 mod 4.
  - seq_err is sticky until reset.
  - Fetching still follows the current SubPixelCount value.
- Reset mid-transaction: ack_pending clears and no ack is issued. The CPU must re-request after reset.

Test Plan:
- Reset, then memory[0x0200]=16'hE041, glyph words at GLYPH_BASE+0x104..0x107 = 16'h1818,16'h243C,16'h4242,16'h0000; TextAreaAddress=0x0200, LineCount=1 -> mem_addr 0x0200 in phase 0 and 0x0105 in phase 1; ASCIIColChar=16'hE041 and GlyphWord=16'h243C from the next phase 3, stable 4 clocks.
- CPU write cpu_addr=0x0300, cpu_wdata=16'hABCD asserted at phase 0 -> mem_we=1 only in phase 2, cpu_ack 1-clock pulse in phase 3, display outputs unchanged.
- CPU read 0x0300 asserted in phase 3 -> granted in phase 3, cpu_ack in phase 0 with cpu_rdata=16'hABCD; phase 0 mem_addr is still TextAreaAddress.
- cpu_req held high for 12 clocks -> exactly one ack per pixel (3 acks), never two consecutive ack cycles, no grant in phases 0/1.
- SubPixelCount sequence 0,1,2,0 -> seq_err=1 and stays 1 until rst=0; rst pulse in phase 2 with a pending grant -> all outputs 0, no cpu_ack.
- GLYPH_BASE=16'hFFFC, char 8'h00, LineCount=3 -> glyph address wraps to 16'hFFFF; char 8'hFF, LineCount=0 -> 16'h03F8.
